// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports (instruction fetch, data load/store) and the
// single-port memory side of the memory arbiter.
//   slave  modport : arbiter view (requests and mem_rdata in; grants, read
//                    responses and memory drive out)
//   master modport : core/memory view (the opposite directions)
// Signals:
//   if_req/if_addr              fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata   fetch grant pulse and registered read response
//   dm_req/dm_we/dm_addr/dm_wdata  data request, held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata   data grant pulse and registered load response
//   mem_we/mem_addr/mem_wdata   to the memory
//   mem_rdata                   combinational read data from the memory
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port word memory between the instruction-fetch port
// (read-only) and the data load/store port. Each access takes two cycles:
// IDLE samples the requests and registers the winner, SERVE_x drives the
// memory for exactly one cycle with the grant pulse, and the read data comes
// back on a registered response in the following cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (drops mem_we immediately, so a
//          store in flight is never committed)
//   bus    mem_arbiter_if.slave, see the interface for the signal list
// Parameters: ADDR_W, DATA_W, MAX_WAIT (consecutive fetch losses before the
// fetch port is forced to win, 1..15).
// Build option: MEM_ARB_RR_EN selects round-robin arbitration on a tie and
// removes the starvation counter; undefined gives data-priority with the
// starvation guard.
// ----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SERVE_IF = 2'd1,
      ST_SERVE_DM = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_if_win;
   logic              w_dm_win;

   logic              r_if_gnt;
   logic              r_dm_gnt;
   logic              r_if_rvalid;
   logic              r_dm_rvalid;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;

`ifdef MEM_ARB_RR_EN
   logic              r_last_win_dm;   // 0: fetch won last, 1: data won last
`else
   localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);
   logic [3:0]        r_wait_cnt;
`endif

   // Winner selection and next state; a winner only exists in IDLE
   always_comb begin
      w_next_state = r_state;
      w_if_win     = 1'b0;
      w_dm_win     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.if_req && bus.dm_req) begin
`ifdef MEM_ARB_RR_EN
               w_if_win = r_last_win_dm;
               w_dm_win = ~r_last_win_dm;
`else
               // data has priority unless fetch has lost MAX_WAIT times in a row
               w_if_win = (r_wait_cnt == LP_MAX_WAIT);
               w_dm_win = (r_wait_cnt != LP_MAX_WAIT);
`endif
            end else begin
               w_if_win = bus.if_req;
               w_dm_win = bus.dm_req;
            end
            if (w_if_win) begin
               w_next_state = ST_SERVE_IF;
            end else if (w_dm_win) begin
               w_next_state = ST_SERVE_DM;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_SERVE_IF: w_next_state = ST_IDLE;
         ST_SERVE_DM: w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Grant pulses, registered winner request and read-response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_gnt    <= 1'b0;
         r_dm_gnt    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rvalid <= 1'b0;
         r_dm_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         // grant and write enable are high exactly during the SERVE cycle
         r_if_gnt    <= w_if_win;
         r_dm_gnt    <= w_dm_win;
         r_mem_we    <= w_dm_win & bus.dm_we;
         if (w_if_win) begin
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
         end else if (w_dm_win) begin
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
         end else begin
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
         end
         // in SERVE_DM, r_mem_we still holds the store flag of this access
         r_if_rvalid <= (r_state == ST_SERVE_IF);
         r_dm_rvalid <= (r_state == ST_SERVE_DM) & ~r_mem_we;
         if (r_state == ST_SERVE_IF) begin
            r_if_rdata <= bus.mem_rdata;
         end
         if ((r_state == ST_SERVE_DM) && !r_mem_we) begin
            r_dm_rdata <= bus.mem_rdata;
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember which port won the most recent grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_win_dm <= 1'b0;
      end else if (w_if_win || w_dm_win) begin
         r_last_win_dm <= w_dm_win;
      end
   end
`else
   // Count consecutive fetch losses, saturating at MAX_WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= 4'd0;
      end else if (w_if_win) begin
         r_wait_cnt <= 4'd0;
      end else if (w_dm_win && bus.if_req && (r_wait_cnt != LP_MAX_WAIT)) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end
`endif

   assign bus.if_gnt    = r_if_gnt;
   assign bus.dm_gnt    = r_dm_gnt;
   assign bus.if_rvalid = r_if_rvalid;
   assign bus.dm_rvalid = r_dm_rvalid;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_rdata  = r_dm_rdata;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboard bench: requesters are fed from per-port request queues, a
// transaction-level reference model decides each arbitration from the
// arbitration rules and pushes the expected grant / read response, and a
// separate monitor pops and compares whenever the arbiter presents a grant
// or a read-valid pulse.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 3;

   typedef struct { bit we; logic [9:0] addr; logic [31:0] wdata; int gap; } req_t;
   typedef struct { bit is_dm; bit we; logic [9:0] addr; logic [31:0] wdata; int due; } gnt_t;
   typedef struct { logic [31:0] data; int due; } rd_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory attached to the arbiter, and the model's own copy
   logic [31:0] mem [0:1023];
   logic [31:0] ref_mem [0:1023];
   assign bus.mem_rdata = mem[bus.mem_addr];

   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'hDEADBEEF;
      if (i == 1) return 32'h0BADF00D;
      if (i >= 16 && i < 32) return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      if (i >= 1008) return 32'hA5A5_0000 | 32'(i);
      return 32'h0000_0000;
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      forever begin
         @(posedge clk);
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   // stimulus sources, model state and scoreboard queues
   req_t src[2][$];      // 0 = fetch port, 1 = data port
   bit   hold[2];
   int   gapc[2];
   gnt_t exp_gnt[$];
   rd_t  exp_rd[2][$];
   bit   obs_order[$];   // 1 = data grant
   bit   m_serve, m_store_pend, m_last_dm;
   int   m_wait;
   logic [9:0]  m_st_addr;
   logic [31:0] m_st_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_flags"}, {27'd0, bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.mem_we}, 32'd0);
      chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
      chk({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
      chk({tag, "_mem_addr"}, {22'd0, bus.mem_addr}, 32'd0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
   endtask

   // Present the next queued request of port p once its idle gap has elapsed
   task automatic drive_port(input int p);
      req_t r;
      if (hold[p]) return;
      if (src[p].size() > 0 && gapc[p] >= src[p][0].gap) begin
         r = src[p].pop_front();
         gapc[p] = 0;
         hold[p] = 1'b1;
         if (p == 0) begin
            bus.if_req = 1'b1; bus.if_addr = r.addr;
         end else begin
            bus.dm_req = 1'b1; bus.dm_we = r.we; bus.dm_addr = r.addr; bus.dm_wdata = r.wdata;
         end
      end else begin
         if (src[p].size() > 0) gapc[p]++;
         if (p == 0) bus.if_req = 1'b0; else bus.dm_req = 1'b0;
      end
   endtask

   // Reference arbitration for the edge that ends the current idle cycle
   task automatic arbitrate();
      bit   win_dm;
      gnt_t g;
      if (!hold[0] && !hold[1]) return;
      if (hold[0] && hold[1]) begin
`ifdef MEM_ARB_RR_EN
         win_dm = !m_last_dm;
`else
         win_dm = (m_wait != MAX_WAIT);
`endif
      end else begin
         win_dm = hold[1];
      end
`ifdef MEM_ARB_RR_EN
      m_last_dm = win_dm;
`else
      if (!win_dm) m_wait = 0;
      else if (hold[0] && m_wait < MAX_WAIT) m_wait++;
`endif
      g.is_dm = win_dm;
      g.due = cyc + 1;
      if (win_dm) begin
         g.we = bus.dm_we; g.addr = bus.dm_addr; g.wdata = bus.dm_wdata;
         if (bus.dm_we) begin
            m_store_pend = 1'b1; m_st_addr = bus.dm_addr; m_st_data = bus.dm_wdata;
         end else begin
            exp_rd[1].push_back('{data: ref_mem[bus.dm_addr], due: cyc + 2});
         end
         hold[1] = 1'b0;
      end else begin
         g.we = 1'b0; g.addr = bus.if_addr; g.wdata = 32'd0;
         exp_rd[0].push_back('{data: ref_mem[bus.if_addr], due: cyc + 2});
         hold[0] = 1'b0;
      end
      exp_gnt.push_back(g);
      m_serve = 1'b1;
   endtask

   // One cycle: in a serve cycle the pending store commits at the coming edge
   task automatic step();
      @(negedge clk);
      if (m_serve) begin
         if (m_store_pend) ref_mem[m_st_addr] = m_st_data;
         m_store_pend = 1'b0;
         m_serve = 1'b0;
      end else begin
         drive_port(0);
         drive_port(1);
         arbitrate();
      end
   endtask

   function automatic bit busy();
      return (src[0].size() > 0) || (src[1].size() > 0) || hold[0] || hold[1] || m_serve ||
             (exp_gnt.size() > 0) || (exp_rd[0].size() > 0) || (exp_rd[1].size() > 0);
   endfunction

   task automatic run(input int budget, input string tag);
      int i = 0;
      while (busy() && i < budget) begin
         step();
         i++;
      end
      chk({tag, "_drain"}, {31'd0, busy()}, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      hold[0] = 1'b0; hold[1] = 1'b0; gapc[0] = 0; gapc[1] = 0;
      m_serve = 1'b0; m_store_pend = 1'b0; m_last_dm = 1'b0; m_wait = 0;
      exp_gnt.delete(); exp_rd[0].delete(); exp_rd[1].delete(); obs_order.delete();
      #1;
      check_zero(tag);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push(input int p, input bit we, input logic [9:0] a, input logic [31:0] d, input int gap);
      src[p].push_back('{we: we, addr: a, wdata: d, gap: gap});
   endtask

   // Monitor: compare grants and read responses against the scoreboard
   initial begin
      gnt_t g;
      rd_t  e;
      bit   rv;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n) begin
            if (bus.if_gnt || bus.dm_gnt) begin
               obs_order.push_back(bus.dm_gnt);
               if (exp_gnt.size() == 0) begin
                  chk("gnt_unexpected", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'd0);
               end else begin
                  g = exp_gnt.pop_front();
                  chk("gnt_port", {30'd0, bus.if_gnt, bus.dm_gnt}, g.is_dm ? 32'd1 : 32'd2);
                  chk("gnt_cycle", cyc, g.due);
                  chk("gnt_mem_addr", {22'd0, bus.mem_addr}, {22'd0, g.addr});
                  chk("gnt_mem_we", {31'd0, bus.mem_we}, {31'd0, g.is_dm & g.we});
                  if (g.is_dm && g.we) chk("gnt_mem_wdata", bus.mem_wdata, g.wdata);
               end
            end else begin
               chk("mem_we_idle", {31'd0, bus.mem_we}, 32'd0);
               if (exp_gnt.size() > 0 && exp_gnt[0].due <= cyc) begin
                  g = exp_gnt.pop_front();
                  chk("gnt_missing", {30'd0, bus.if_gnt, bus.dm_gnt}, g.is_dm ? 32'd1 : 32'd2);
               end
            end
            for (int p = 0; p < 2; p++) begin
               rv = (p == 0) ? bus.if_rvalid : bus.dm_rvalid;
               if (rv || (exp_rd[p].size() > 0 && exp_rd[p][0].due <= cyc)) begin
                  if (exp_rd[p].size() == 0) begin
                     chk(p == 0 ? "if_rvalid_unexpected" : "dm_rvalid_unexpected", {31'd0, rv}, 32'd0);
                  end else begin
                     e = exp_rd[p].pop_front();
                     chk(p == 0 ? "if_rvalid" : "dm_rvalid", {31'd0, rv}, 32'd1);
                     chk(p == 0 ? "if_rvalid_cycle" : "dm_rvalid_cycle", cyc, e.due);
                     chk(p == 0 ? "if_rdata" : "dm_rdata",
                         (p == 0) ? bus.if_rdata : bus.dm_rdata, e.data);
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Main sequence
   initial begin
      logic [7:0] got_ord, exp_ord;
      logic [9:0] ra;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      #1;
      do_reset("reset");

      // fetch read of mem[0]
      push(0, 1'b0, 10'd0, 32'd0, 0);
      run(40, "t1");

      // store, load back, load of an unwritten word
      push(1, 1'b1, 10'd2, 32'h12345678, 0);
      push(1, 1'b0, 10'd2, 32'd0, 0);
      push(1, 1'b0, 10'd3, 32'd0, 0);
      run(40, "t2");
      chk("t2_mem2", mem[2], 32'h12345678);

      // both ports requesting continuously
      do_reset("t3_reset");
      for (int i = 0; i < 8; i++) begin
         push(0, 1'b0, 10'(i), 32'd0, 0);
         push(1, 1'b0, 10'(16 + i), 32'd0, 0);
      end
      run(100, "t3");
      got_ord = '0;
      exp_ord = '0;
      for (int k = 0; k < 8; k++) begin
         if (obs_order.size() > k) got_ord[k] = obs_order[k];
`ifdef MEM_ARB_RR_EN
         exp_ord[k] = (k % 2 == 0);
`else
         exp_ord[k] = (k % 4 != 3);
`endif
      end
      chk("t3_order", {24'd0, got_ord}, {24'd0, exp_ord});
      chk("t3_count", obs_order.size(), 32'd16);

      // reset while a store is being served
      push(1, 1'b1, 10'd5, 32'hCAFEF00D, 0);
      for (int i = 0; i < 4 && !m_serve; i++) step();
      @(posedge clk);
      #3;
      chk("t5_mem_we_before", {31'd0, bus.mem_we}, 32'd1);
      do_reset("t5_reset");
      repeat (2) @(negedge clk);
      chk("t5_mem5", mem[5], 32'd0);
      push(1, 1'b0, 10'd5, 32'd0, 0);
      run(40, "t5");

      // back-to-back fetches
      push(0, 1'b0, 10'd0, 32'd0, 0);
      push(0, 1'b0, 10'd1, 32'd0, 0);
      run(40, "t6");

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? 10'(1008 + $urandom_range(0, 15)) : 10'($urandom_range(0, 15));
         push(0, 1'b0, ra, 32'd0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
         ra = ($urandom_range(0, 3) == 0) ? 10'(1008 + $urandom_range(0, 15)) : 10'($urandom_range(0, 15));
         push(1, 1'($urandom_range(0, 1)), ra, $urandom, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      run(4000, "rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port word memory (clk, write_enable, 10-bit addr, 32-bit write_data, combinational read_data, write committed at posedge).
- Shares the memory between the instruction-fetch port (read-only) and the data load/store port.
- Registers each winning request, drives the memory for exactly one cycle, and returns read data on a registered response.
- Sits between the core's IF/MEM stages and the memory instance.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, data width.
- MAX_WAIT, 3, consecutive IF losses before IF is forced to win; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request; held with if_addr until if_gnt.
- if_addr  input  ADDR_W  fetch word address.
- if_gnt  output  1  one-cycle pulse: fetch request accepted.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DATA_W  fetch read data.
- dm_req  input  1  data request; held with dm_we, dm_addr and dm_wdata until dm_gnt.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  ADDR_W  data word address.
- dm_wdata  input  DATA_W  store data.
- dm_gnt  output  1  one-cycle pulse: data request accepted.
- dm_rvalid  output  1  one-cycle pulse, loads only: dm_rdata valid.
- dm_rdata  output  DATA_W  load read data.
- mem_we  output  1  to memory write_enable.
- mem_addr  output  ADDR_W  to memory addr.
- mem_wdata  output  DATA_W  to memory write_data.
- mem_rdata  input  DATA_W  from memory read_data (combinational).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wait_cnt=0; last_win=IF.
  - All outputs 0, including mem_we, which drops immediately.
  - A store in flight in SERVE_DM is aborted; the memory is not written.
- FSM states: IDLE, SERVE_IF, SERVE_DM.
- IDLE (no request): stays in IDLE.
- IDLE (any request): picks a winner and latches the winner's addr/we/wdata into mem_addr/we_q/mem_wdata. Next state is SERVE_IF or SERVE_DM.
- Winner selection (default):
  - DM wins over IF when both request.
  - Exception: when wait_cnt==MAX_WAIT, IF wins.
- wait_cnt:
  - Increments when IF requests and loses; saturates at MAX_WAIT.
  - Clears when IF is granted.
- SERVE_x:
  - x_gnt=1 for this cycle.
  - mem_we = we_q & (state==SERVE_DM). mem_we is never 1 in SERVE_IF.
  - mem_rdata is captured into x_rdata at the clock edge.
  - x_rvalid is set for the next cycle if the access was a read.
  - Next state is always IDLE.
- Latency and throughput:
  - req sampled in cycle N → gnt in cycle N+1 → rvalid and rdata in cycle N+2.
  - One access per 2 cycles.
- Store timing: committed at the rising edge ending the SERVE_DM cycle. A load to the same address granted later returns the new data.
- x_rdata holds its value until the next read grant for the same port. x_rvalid is a single-cycle pulse.
- A requester may change req/addr in the cycle after gnt. IDLE samples the new values. A req still high then is a new request.
- Request inputs are ignored while in SERVE_x. No queueing; requests are level-held, never lost.
- Address width: no range check; addresses wrap within ADDR_W naturally.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. On a tie, the port not equal to last_win wins; last_win updates on each grant.
  - wait_cnt and MAX_WAIT are unused (logic removed).
- Undefined: DM-priority with the starvation guard, as above.

Test Plan:
1. Reset then IF read:
   - Preload mem[0]=32'hDEADBEEF; if_req=1, if_addr=0 in cycle N.
   - Expect if_gnt in N+1, if_rvalid=1 with if_rdata=32'hDEADBEEF in N+2, mem_we=0 throughout.
2. DM store then load:
   - dm_we=1, dm_addr=2, dm_wdata=32'h12345678; expect dm_gnt and mem_we=1 for one cycle, and no dm_rvalid.
   - Then a load from addr 2: expect dm_rdata=32'h12345678.
   - Then a load from addr 3 (unwritten): expect 0.
3. Simultaneous requests, default build:
   - if_req and dm_req both held high continuously.
   - Grant order: DM,DM,DM,IF,DM,DM,DM,IF, with each IF grant occurring when wait_cnt==3.
4. Same stimulus with MEM_ARB_RR_EN:
   - Grant order: DM,IF,DM,IF... (last_win=IF after reset, so DM first).
5. Reset mid-store:
   - Assert rst_n=0 during SERVE_DM with dm_we=1, addr=5, data=32'hCAFEF00D.
   - Expect mem_we=0 immediately and all outputs 0. After release, mem[5] still 0 and state IDLE.
6. Back-to-back IF:
   - if_req held with if_addr 0→1 updated in the cycle after each gnt.
   - Expect gnts 2 cycles apart and rdata matching mem[0] then mem[1].
